// File: rtl/ppr_pkg.sv
// Shared definitions for the final carry-propagate adder (ppr_final_cpa).
// Holds the default operand width and slice width, the derived pipeline
// depth, and the record that one pipeline stage hands to the next.
package ppr_pkg;

  localparam int PPR_WIDTH  = 16;                    // product width in bits
  localparam int PPR_SEG    = 4;                     // bits added per stage
  localparam int PPR_STAGES = PPR_WIDTH / PPR_SEG;   // pipeline depth

  // One in-flight operation as it sits between two stages.
  //   acc        : bits already summed by earlier stages (upper bits still 0)
  //   pend_sum   : sum-row bits not yet consumed (consumed bits cleared)
  //   pend_carry : carry-row bits not yet consumed (consumed bits cleared)
  //   carry      : carry out of the highest bit summed so far
  typedef struct packed {
    logic                 valid;
    logic [PPR_WIDTH-1:0] acc;
    logic [PPR_WIDTH-1:0] pend_sum;
    logic [PPR_WIDTH-1:0] pend_carry;
    logic                 carry;
  } stage_rec_t;

endpackage

// File: rtl/ppr_final_cpa_if.sv
// Handshake bundle for ppr_final_cpa.
//   Input side : in_valid / in_ready, sum_row, carry_row, cin
//   Output side: out_valid / out_ready, result, cout
// slave  : the adder itself.
// master : the environment (compressor tree upstream plus result consumer).
interface ppr_final_cpa_if #(
  parameter int WIDTH = ppr_pkg::PPR_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_row;
  logic [WIDTH-1:0] carry_row;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;

  modport slave (
    input  in_valid, sum_row, carry_row, cin, out_ready,
    output in_ready, out_valid, result, cout
  );

  modport master (
    output in_valid, sum_row, carry_row, cin, out_ready,
    input  in_ready, out_valid, result, cout
  );

endinterface

// File: rtl/ppr_cpa_slice.sv
// One pipeline stage of the final adder: adds bits [OFF +: SEG] of the
// pending sum and carry rows plus the incoming carry, deposits the SEG result
// bits into the accumulated result and registers the whole record when en_i.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   en_i         : global pipeline advance
//   rec_i        : record from the previous stage (or the input side)
//   rec_o        : registered record for the next stage
module ppr_cpa_slice
  import ppr_pkg::*;
#(
  parameter int SEG = PPR_SEG,
  parameter int OFF = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_i,
  input  stage_rec_t rec_i,
  output stage_rec_t rec_o
);

  stage_rec_t     rec_d;
  stage_rec_t     rec_q;
  logic [SEG:0]   sum_w;

  always_comb begin
    // NOTE: start from a full default so every field is assigned on every pass;
    // a field left unassigned on some path would infer a latch.
    rec_d = rec_i;
    sum_w = {1'b0, rec_i.pend_sum[OFF +: SEG]}
          + {1'b0, rec_i.pend_carry[OFF +: SEG]}
          + {{SEG{1'b0}}, rec_i.carry};
    rec_d.acc[OFF +: SEG]        = sum_w[SEG-1:0];
    rec_d.carry                  = sum_w[SEG];
    // Consumed operand bits are dropped so later stages carry only live data.
    rec_d.pend_sum[OFF +: SEG]   = '0;
    rec_d.pend_carry[OFF +: SEG] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the data fields are reset as well as valid, because the final
      // stage drives result/cout directly and those must read 0 out of reset.
      rec_q <= '0;
    end else if (en_i) begin
      // NOTE: non-blocking so every stage samples its neighbour's old value.
      rec_q <= rec_d;
    end
  end

  assign rec_o = rec_q;

endmodule

// File: rtl/ppr_final_cpa.sv
// Final carry-propagate adder after the 4:2 partial-product-reduction tree.
// Computes result = (sum_row + carry_row + cin) mod 2^WIDTH and cout, SEG bits
// per stage over WIDTH/SEG stages, with registered carries between stages.
// A single global advance (adv = out_ready | ~out_valid) moves the whole
// pipe, bubbles included; in_ready is adv, so it depends only on out_ready
// and registered state.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : in_valid/in_ready/sum_row/carry_row/cin,
//                  out_valid/out_ready/result/cout
module ppr_final_cpa
  import ppr_pkg::*;
#(
  parameter int WIDTH = PPR_WIDTH,
  parameter int SEG   = PPR_SEG
) (
  input  logic               clk,
  input  logic               reset_n,
  ppr_final_cpa_if.slave     bus
);

  localparam int STAGES = WIDTH / SEG;

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("ppr_final_cpa: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
  end
  // The stage record is sized from the package, so the width is set there.
  if (WIDTH != PPR_WIDTH) begin : g_bad_width
    $error("ppr_final_cpa: WIDTH (%0d) must equal ppr_pkg::PPR_WIDTH (%0d)", WIDTH, PPR_WIDTH);
  end

  logic       adv;
  stage_rec_t rec_in;
  stage_rec_t rec_out [STAGES];

  assign adv          = bus.out_ready | ~rec_out[STAGES-1].valid;
  assign bus.in_ready = adv;

  // Without an operand this is a bubble; it still flows so the pipe never
  // collapses or reorders.
  always_comb begin
    rec_in            = '0;
    rec_in.valid      = bus.in_valid;
    rec_in.pend_sum   = bus.sum_row;
    rec_in.pend_carry = bus.carry_row;
    rec_in.carry      = bus.cin;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      ppr_cpa_slice #(.SEG(SEG), .OFF(0)) u_slice (
        .clk    (clk),
        .reset_n(reset_n),
        .en_i   (adv),
        .rec_i  (rec_in),
        .rec_o  (rec_out[0])
      );
    end else begin : g_next
      ppr_cpa_slice #(.SEG(SEG), .OFF(k*SEG)) u_slice (
        .clk    (clk),
        .reset_n(reset_n),
        .en_i   (adv),
        .rec_i  (rec_out[k-1]),
        .rec_o  (rec_out[k])
      );
    end
  end

  assign bus.out_valid = rec_out[STAGES-1].valid;
  assign bus.result    = rec_out[STAGES-1].acc;
  assign bus.cout      = rec_out[STAGES-1].carry;

endmodule

// File: tb/tb_ppr_final_cpa.sv
// Directed bench for ppr_final_cpa: reset state, exact latency, a table of
// hand-computed sums streamed back-to-back, a 5-cycle output stall and an
// asynchronous reset with operations in flight.
module tb_ppr_final_cpa;
  import ppr_pkg::*;

  localparam int W = PPR_WIDTH;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic         ci;
    logic [W-1:0] exp_res;
    logic         exp_cout;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  ppr_final_cpa_if #(.WIDTH(W)) bus ();

  ppr_final_cpa dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Returns 1 ns after the rising edge, where outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input vec_t t);
    bus.in_valid  = v;
    bus.sum_row   = t.s;
    bus.carry_row = t.c;
    bus.cin       = t.ci;
  endtask

  vec_t tbl [10];
  vec_t stall_ops [4];
  vec_t extra;
  vec_t idle;

  initial begin
    int n_out;
    int first_c;
    int last_c;
    int n_valid;

    checks   = 0;
    failures = 0;

    // Hand-computed reference sums (16-bit, unsigned, wrapping).
    tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    tbl[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[5] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0};
    tbl[6] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0};
    tbl[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[8] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    tbl[9] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};

    stall_ops[0] = '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0};
    stall_ops[1] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
    stall_ops[2] = '{16'hFFF0, 16'h0010, 1'b0, 16'h0000, 1'b1};
    stall_ops[3] = '{16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1};
    extra        = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
    idle         = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

    // ---------------- reset state ----------------
    reset_n       = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, idle);
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    32'(bus.result),    32'h0);
    check("rst_cout",      32'(bus.cout),      32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    reset_n = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid) n_valid++;
    end
    check("idle_no_valid", 32'(n_valid), 32'd0);

    // ---------------- single op, exact latency ----------------
    for (int c = 0; c < 7; c++) begin
      drive(c == 0, (c == 0) ? tbl[0] : idle);
      tick();
      check($sformatf("single_valid_c%0d", c), 32'(bus.out_valid), 32'(c == PPR_STAGES - 1));
      if (c == PPR_STAGES - 1) begin
        check("single_result", 32'(bus.result), 32'(tbl[0].exp_res));
        check("single_cout",   32'(bus.cout),   32'(tbl[0].exp_cout));
      end
    end

    // ---------------- table, streamed back-to-back ----------------
    n_out   = 0;
    first_c = -1;
    last_c  = -1;
    for (int c = 0; c < 10 + 8; c++) begin
      drive(c < 10, (c < 10) ? tbl[c] : idle);
      tick();
      if (bus.out_valid) begin
        if (n_out < 10) begin
          check($sformatf("b2b_result_%0d", n_out), 32'(bus.result), 32'(tbl[n_out].exp_res));
          check($sformatf("b2b_cout_%0d", n_out),   32'(bus.cout),   32'(tbl[n_out].exp_cout));
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        n_out++;
      end
    end
    check("b2b_count",    32'(n_out),            32'd10);
    check("b2b_latency",  32'(first_c),          32'(PPR_STAGES - 1));
    check("b2b_span",     32'(last_c - first_c), 32'd9);

    // ---------------- stall ----------------
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, stall_ops[c]);
      tick();
    end
    check("fill_valid",  32'(bus.out_valid), 32'd1);
    check("fill_result", 32'(bus.result),    32'(stall_ops[0].exp_res));
    bus.out_ready = 1'b0;
    drive(1'b1, extra);   // offered during the stall, must never be taken
    #1;
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("stall_valid_%0d", c),    32'(bus.out_valid), 32'd1);
      check($sformatf("stall_result_%0d", c),   32'(bus.result),    32'(stall_ops[0].exp_res));
      check($sformatf("stall_cout_%0d", c),     32'(bus.cout),      32'(stall_ops[0].exp_cout));
      check($sformatf("stall_in_ready_%0d", c), 32'(bus.in_ready),  32'd0);
    end
    drive(1'b0, idle);
    bus.out_ready = 1'b1;
    #1;
    n_out = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid) begin
        if (n_out < 4) begin
          check($sformatf("drain_result_%0d", n_out), 32'(bus.result), 32'(stall_ops[n_out].exp_res));
          check($sformatf("drain_cout_%0d", n_out),   32'(bus.cout),   32'(stall_ops[n_out].exp_cout));
        end
        n_out++;
      end
      tick();
    end
    check("drain_count", 32'(n_out), 32'd4);

    // ---------------- reset mid-flight ----------------
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, tbl[c + 2]);
      tick();
    end
    drive(1'b0, idle);
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    #1 reset_n = 1'b0;       // well away from any clock edge
    #1;
    check("async_rst_valid",  32'(bus.out_valid), 32'd0);
    check("async_rst_result", 32'(bus.result),    32'h0);
    check("async_rst_cout",   32'(bus.cout),      32'd0);
    #1 reset_n = 1'b1;
    n_valid = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.out_valid) n_valid++;
    end
    check("post_rst_no_stale", 32'(n_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
